// File: rtl/xor_stream_pkg.sv
// xor_stream_pkg: shared types and constants for the xor_stream block.
package xor_stream_pkg;

  typedef enum logic {
    XS_IDLE = 1'b0,
    XS_BUSY = 1'b1
  } xs_state_t;

  localparam logic XS_MODE_BITWISE = 1'b0;
  localparam logic XS_MODE_ACCUM   = 1'b1;
  localparam int   XS_CNT_W        = 16;

  // Saturating increment for the beat counter.
  function automatic logic [XS_CNT_W-1:0] xs_sat_inc(input logic [XS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/xor_stream_if.sv
// xor_stream_if: operand stream in, result stream out.
// out_beats exists only when XOR_STREAM_CNT_EN is defined.
interface xor_stream_if #(parameter int WIDTH = 8);
  import xor_stream_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;
  logic             out_last;
  logic             out_par;
`ifdef XOR_STREAM_CNT_EN
  logic [XS_CNT_W-1:0] out_beats;
`endif

  // Block side.
  modport slave (
    input  in_valid, in_x, in_y, in_last, mode, out_ready,
    output in_ready, out_valid, out_z, out_last, out_par
`ifdef XOR_STREAM_CNT_EN
    , output out_beats
`endif
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_x, in_y, in_last, mode, out_ready,
    input  in_ready, out_valid, out_z, out_last, out_par
`ifdef XOR_STREAM_CNT_EN
    , input out_beats
`endif
  );

endinterface

// File: rtl/xor_stream_oreg.sv
// xor_stream_oreg: one-entry output register slice with valid/ready.
// Accepts when empty or when the held entry drains in the same cycle,
// so back-to-back traffic flows with no bubble.
module xor_stream_oreg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on accept, otherwise empty once the consumer takes the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xor_stream.sv
// xor_stream: registered XOR stream element, bitwise or packet-accumulate,
// with packet parity on the last beat. Optional beat counter on
// out_beats when XOR_STREAM_CNT_EN is defined.
module xor_stream
  import xor_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  xor_stream_if.slave bus
);

`ifdef XOR_STREAM_CNT_EN
  localparam int PW = XS_CNT_W + WIDTH + 2;
`else
  localparam int PW = WIDTH + 2;
`endif

  xs_state_t        r_state, w_state_nxt;
  logic             r_mode;
  logic [WIDTH-1:0] r_acc;
  logic             r_par;

  logic             w_in_ready, w_accept, w_first, w_mode;
  logic [WIDTH-1:0] w_d, w_acc_new, w_z;
  logic             w_par_new, w_par_out;
  logic [PW-1:0]    w_pld_in, w_pld_out;
  logic             w_out_valid;

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_first   = (r_state == XS_IDLE);
  // Mode is taken live on the first beat, then held for the packet.
  assign w_mode    = w_first ? bus.mode : r_mode;
  assign w_d       = bus.in_x ^ bus.in_y;
  assign w_acc_new = (w_first ? '0 : r_acc) ^ w_d;
  assign w_par_new = (w_first ? 1'b0 : r_par) ^ (^w_d);
  assign w_z       = (w_mode == XS_MODE_ACCUM) ? w_acc_new : w_d;
  assign w_par_out = bus.in_last ? w_par_new : 1'b0;

`ifdef XOR_STREAM_CNT_EN
  logic [XS_CNT_W-1:0] r_cnt, w_cnt_new, w_beats;
  assign w_cnt_new = xs_sat_inc(w_first ? '0 : r_cnt);
  assign w_beats   = bus.in_last ? w_cnt_new : '0;

  // Beat counter, cleared at packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (w_accept && bus.in_last) r_cnt <= '0;
    else if (w_accept)                r_cnt <= w_cnt_new;
  end

  assign w_pld_in = {w_beats, w_par_out, bus.in_last, w_z};
  assign bus.out_beats = w_pld_out[WIDTH+2 +: XS_CNT_W];
`else
  assign w_pld_in = {w_par_out, bus.in_last, w_z};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= XS_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: packet boundary follows in_last of accepted beats.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = bus.in_last ? XS_IDLE : XS_BUSY;
  end

  // Packet accumulators and latched mode; cleared after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= XS_MODE_BITWISE;
      r_acc  <= '0;
      r_par  <= 1'b0;
    end else if (w_accept) begin
      if (w_first) r_mode <= bus.mode;
      if (bus.in_last) begin
        r_acc <= '0;
        r_par <= 1'b0;
      end else begin
        r_acc <= w_acc_new;
        r_par <= w_par_new;
      end
    end
  end

  xor_stream_oreg #(.PW(PW)) u_oreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.in_valid),
    .o_ready (w_in_ready),
    .i_data  (w_pld_in),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_pld_out)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_z     = w_pld_out[WIDTH-1:0];
  assign bus.out_last  = w_pld_out[WIDTH];
  assign bus.out_par   = w_pld_out[WIDTH+1];

endmodule

// File: doc/xor_stream.md
# xor_stream

Parametrised, registered successor to the single-bit XOR gate. It operates on WIDTH-bit operand pairs under a valid/ready handshake and groups beats into packets delimited by `in_last`. In bitwise mode each result is `x ^ y`. In accumulate mode each result is a running XOR across the packet. Every packet's last beat also carries a packet parity bit. The block sits between a stream producer and consumer as a one-stage pipelined data-path element.

## Interface
- `WIDTH`, default 8: operand and result width, ≥1.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: block accepts a beat this cycle.
- `in_x`  in  WIDTH: operand x.
- `in_y`  in  WIDTH: operand y.
- `in_last`  in  1: final beat of the packet.
- `mode`  in  1: 0 = bitwise, 1 = accumulate; sampled on the first beat of each packet.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_z`  out  WIDTH: result.
- `out_last`  out  1: result is the last of its packet.
- `out_par`  out  1: packet parity; meaningful only when `out_last`=1, otherwise 0.
- `out_beats`  out  16: beat count of the packet (present only with `XOR_STREAM_CNT_EN`).

One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- **Accept rule:** a beat is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`.
- **FSM states:** IDLE (awaiting first beat) and BUSY (mid-packet).
  - IDLE→BUSY on an accepted beat with `in_last`=0.
  - BUSY→IDLE on an accepted beat with `in_last`=1.
  - IDLE→IDLE on a single-beat packet.
- **Mode:**
  - `mode` is latched into `mode_q` on an accepted beat in IDLE.
  - Changes to `mode` while in BUSY are ignored.
- **Data path, d = `in_x ^ in_y`:**
  - Bitwise mode: `out_z` ← d.
  - Accumulate mode: `acc` ← `acc ^ d` and `out_z` ← that new value. On the first beat `acc` is treated as 0.
- **Parity:**
  - `par_acc` ← `par_acc ^ (^d)` on every accepted beat.
  - On the last beat, `out_par` ← the final value, and `par_acc` and `acc` clear to 0.
- **Output hold:** while `out_valid && !out_ready`, all outputs hold stable and no beat is accepted.
- **Reset:**
  - All state clears and the FSM returns to IDLE.
  - Outputs reset to `out_valid`=0, `out_z`=0, `out_last`=0, `out_par`=0, `out_beats`=0; `in_ready`=1 once reset is released.
  - A packet in flight when reset asserts is discarded; no partial result is emitted.

## Timing
- **Latency:** 1 cycle. A beat accepted at edge N appears on the outputs after edge N, i.e. `out_valid`=1 in cycle N+1.
- **Throughput:** 1 beat/cycle while `out_ready`=1.
- **Simultaneous events:** when the output drains and a new beat is accepted in the same cycle, the new result replaces the old with no bubble.
- **Asynchronous path:** reset asserts asynchronously; deassertion is synchronous to `clk`.

## Configuration
- Macro: `XOR_STREAM_CNT_EN`.
- **Defined:**
  - A 16-bit beat counter increments per accepted beat and saturates at 16'hFFFF.
  - On the last beat it drives `out_beats` with the packet's count, including the last beat; `out_beats` is 0 on other beats.
  - The counter clears after the last beat and on reset.
- **Undefined:** the `out_beats` port and the counter are absent. All other behaviour is identical.

## Structure
- **Package `xor_stream_pkg`:**
  - State enum `xs_state_t` {XS_IDLE, XS_BUSY}.
  - Constants `XS_MODE_BITWISE`=1'b0 and `XS_MODE_ACCUM`=1'b1.
  - `XS_CNT_W`=16.
- **Sub-module `xor_stream_oreg`:** the output register slice, holding `out_*` and the valid/ready logic and parameterised by payload width.
- **Top level:** FSM, accumulators and the optional counter.

## Test plan
All scenarios use WIDTH=8.
1. Bitwise single-beat: mode=0, x=8'hA5, y=8'h0F, last=1 → next cycle `out_z`=8'hAA, `out_last`=1, `out_par`=0.
2. Accumulate 3-beat: mode=1, x=8'h01/8'h02/8'h04, y=8'h00, last on beat 3 → `out_z` 8'h01, 8'h03, 8'h07; `out_par`=1 on the last beat only.
3. Backpressure:
   - `out_ready`=0 for 3 cycles with a result pending → `out_z` held, `in_ready`=0, no beat consumed.
   - On release, the next beat follows with no loss or duplication.
4. Mid-packet mode change: beat 1 with mode=1 (x=8'h10, y=0), beat 2 with mode=0 (x=8'h01, y=0, last) → beat-2 `out_z`=8'h11, i.e. the packet stays in accumulate mode.
5. Reset mid-packet:
   - Assert `rst_n`=0 after 2 of 4 beats → all outputs 0 asynchronously.
   - Next packet (mode=1, x=8'h03, y=0, last) → `out_z`=8'h03, `out_par`=0.
6. `XOR_STREAM_CNT_EN` defined: 5-beat packet → `out_beats`=5 on the last beat and 0 on beats 1–4.
